// File: rtl/pio_pkg.sv
// Shared constants for the PIO family: register word addresses and the
// capture / interrupt mode encodings.
package pio_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA = 2'd0,
        ADDR_RSVD = 2'd1,
        ADDR_MASK = 2'd2,
        ADDR_EDGE = 2'd3
    } pio_addr_e;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

    localparam int BUS_WIDTH = 32;

endpackage

// File: rtl/pio_in_edge_irq_if.sv
// Avalon-MM slave bus bundle for the PIO register block.
interface pio_in_edge_irq_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/pio_sync_edge.sv
// Input synchroniser plus one-cycle edge detector, shared by the PIO variants.
module pio_sync_edge
    import pio_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] data_sync,
    output logic [WIDTH-1:0] edge_det
);

    logic [WIDTH-1:0] data_d1_reg;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign data_sync = in_port;
        end else begin : g_sync
            logic [WIDTH-1:0] stage_reg [SYNC_STAGES];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        stage_reg[i] <= '0;
                    end
                end else begin
                    stage_reg[0] <= in_port;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        stage_reg[i] <= stage_reg[i-1];
                    end
                end
            end

            assign data_sync = stage_reg[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_d1_reg <= '0;
        end else begin
            data_d1_reg <= data_sync;
        end
    end

    // Per-bit edge terms; the mode is a constant so the unused branches fold away.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_edge
            assign rise[gi] = data_sync[gi] & ~data_d1_reg[gi];
            assign fall[gi] = ~data_sync[gi] & data_d1_reg[gi];
            assign edge_det[gi] = (EDGE_TYPE == EDGE_RISE) ? rise[gi] :
                                  (EDGE_TYPE == EDGE_FALL) ? fall[gi] :
                                                             (rise[gi] | fall[gi]);
        end
    endgenerate

endmodule

// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO with synchroniser, sticky edge capture (write-1-to-clear)
// and a maskable level- or edge-sourced interrupt.
module pio_in_edge_irq
    import pio_pkg::*;
#(
    parameter int               WIDTH       = 1,
    parameter int               SYNC_STAGES = 2,
    parameter int               EDGE_TYPE   = EDGE_RISE,
    parameter int               IRQ_TYPE    = IRQ_LEVEL,
    parameter logic [WIDTH-1:0] RESET_MASK  = '0
) (
    input  logic             clk,
    input  logic             reset,
    pio_in_edge_irq_if.slave bus,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0]     data_sync;
    logic [WIDTH-1:0]     edge_det;
    logic [WIDTH-1:0]     irq_mask_reg;
    logic [WIDTH-1:0]     irq_mask_next;
    logic [WIDTH-1:0]     edge_capture_reg;
    logic [WIDTH-1:0]     edge_capture_next;
    logic [WIDTH-1:0]     wdata;
    logic [WIDTH-1:0]     clr;
    logic [BUS_WIDTH-1:0] rd_mux;
    logic [BUS_WIDTH-1:0] readdata_reg;
    logic                 wr_en;
    logic                 unused_wdata;

    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk       (clk),
        .reset     (reset),
        .in_port   (in_port),
        .data_sync (data_sync),
        .edge_det  (edge_det)
    );

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign wdata        = bus.writedata[WIDTH-1:0];
    assign unused_wdata = ^bus.writedata;

    assign clr           = (wr_en && (bus.address == ADDR_EDGE)) ? wdata : '0;
    assign irq_mask_next = (wr_en && (bus.address == ADDR_MASK)) ? wdata : irq_mask_reg;

    // A new edge dominates a simultaneous clear so no event is ever dropped.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_capture
            assign edge_capture_next[gi] = edge_det[gi] | (edge_capture_reg[gi] & ~clr[gi]);
        end
    endgenerate

    always_comb begin
        rd_mux = '0;
        case (pio_addr_e'(bus.address))
            ADDR_DATA: rd_mux[WIDTH-1:0] = data_sync;
            ADDR_RSVD: rd_mux = '0;
            ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask_reg;
            ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_capture_reg;
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata_reg     <= '0;
            irq_mask_reg     <= RESET_MASK;
            edge_capture_reg <= '0;
        end else begin
            readdata_reg     <= rd_mux;
            irq_mask_reg     <= irq_mask_next;
            edge_capture_reg <= edge_capture_next;
        end
    end

    assign bus.readdata = readdata_reg;

    // irq is built from registered state only, so it never follows the bus combinationally.
    generate
        if (IRQ_TYPE == IRQ_LEVEL) begin : g_irq_level
            assign irq = |(data_sync & irq_mask_reg);
        end else begin : g_irq_edge
            assign irq = |(edge_capture_reg & irq_mask_reg);
        end
    endgenerate

endmodule
